// File: rtl/lc4_pkg.sv
// Shared LC4 condition-code definitions: NZP bit positions, reset value,
// canonical compare results and a branch-match helper.
package lc4_pkg;

    localparam int NZP_N = 2;
    localparam int NZP_Z = 1;
    localparam int NZP_P = 0;

    typedef logic [2:0] nzp_t;

    localparam nzp_t NZP_RESET = 3'b010;

    localparam logic [15:0] CMP_GT = 16'h0001;
    localparam logic [15:0] CMP_EQ = 16'h0000;
    localparam logic [15:0] CMP_LT = 16'hFFFF;

    // A BR[nzp] is taken when any requested condition bit is currently set.
    function automatic logic nzp_match(input nzp_t mask, input nzp_t cc);
        return |(mask & cc);
    endfunction

endpackage

// File: rtl/lc4_nzp_branch_unit_if.sv
// Branch request and redirect result channels of lc4_nzp_branch_unit.
// The unit is the slave; the issuing/fetch side is the master.
interface lc4_nzp_branch_unit_if #(
    parameter int PC_W = 16
);
    import lc4_pkg::*;

    logic            br_valid;
    logic            br_ready;
    nzp_t            br_mask;
    logic [PC_W-1:0] br_pc;
    logic [PC_W-1:0] br_target;

    logic            res_valid;
    logic            res_ready;
    logic            res_taken;
    logic [PC_W-1:0] res_next_pc;

    modport master (
        output br_valid, br_mask, br_pc, br_target, res_ready,
        input  br_ready, res_valid, res_taken, res_next_pc
    );

    modport slave (
        input  br_valid, br_mask, br_pc, br_target, res_ready,
        output br_ready, res_valid, res_taken, res_next_pc
    );

endinterface

// File: rtl/lc4_nzp_decode.sv
// Combinational reduction of a 16-bit result word to a one-hot {N,Z,P}
// condition code, treating the word as signed.
module lc4_nzp_decode
    import lc4_pkg::*;
(
    input  logic [15:0] value,
    output nzp_t        nzp
);

    always_comb begin
        nzp = '0;
        if (value[15]) begin
            nzp[NZP_N] = 1'b1;
        end else if (value == 16'h0000) begin
            nzp[NZP_Z] = 1'b1;
        end else begin
            nzp[NZP_P] = 1'b1;
        end
    end

endmodule

// File: rtl/lc4_nzp_branch_unit.sv
// LC4 NZP register and BR[nzp] resolver with a one-entry result buffer.
// Define LC4_NZP_BYPASS_EN to let a same-cycle NZP write feed branch resolution.
module lc4_nzp_branch_unit
    import lc4_pkg::*;
#(
    parameter int PC_W  = 16,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_valid,
    input  logic                  wb_nzp_we,
    input  logic [15:0]           wb_value,
    lc4_nzp_branch_unit_if.slave  bus,
    output nzp_t                  nzp,
    output logic [CNT_W-1:0]      taken_cnt
);

    nzp_t             nzp_reg;
    logic             res_valid_reg;
    logic             res_taken_reg;
    logic [PC_W-1:0]  res_next_pc_reg;
    logic [CNT_W-1:0] taken_cnt_reg;

    nzp_t             nzp_wb;
    nzp_t             nzp_used;
    logic [2:0]       cond_hit;
    logic             taken_next;
    logic             nzp_write;
    logic             br_ready_int;
    logic             accept;
    logic [PC_W-1:0]  pc_inc;

    assign nzp_write = wb_valid && wb_nzp_we;

    lc4_nzp_decode u_wb_decode (
        .value (wb_value),
        .nzp   (nzp_wb)
    );

`ifdef LC4_NZP_BYPASS_EN
    nzp_t nzp_byp;

    // Separate decode keeps the bypass path independent of the write path.
    lc4_nzp_decode u_bypass_decode (
        .value (wb_value),
        .nzp   (nzp_byp)
    );

    assign nzp_used = nzp_write ? nzp_byp : nzp_reg;
`else
    assign nzp_used = nzp_reg;
`endif

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_cond
            assign cond_hit[gi] = bus.br_mask[gi] & nzp_used[gi];
        end
    endgenerate

    assign taken_next = |cond_hit;

    // Space is available when the buffer is empty or is draining this cycle.
    assign br_ready_int = !res_valid_reg || bus.res_ready;
    assign accept       = bus.br_valid && br_ready_int;
    assign pc_inc       = bus.br_pc + PC_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            nzp_reg         <= NZP_RESET;
            res_valid_reg   <= 1'b0;
            res_taken_reg   <= 1'b0;
            res_next_pc_reg <= '0;
            taken_cnt_reg   <= '0;
        end else begin
            if (nzp_write) begin
                nzp_reg <= nzp_wb;
            end

            if (accept) begin
                res_valid_reg   <= 1'b1;
                res_taken_reg   <= taken_next;
                res_next_pc_reg <= taken_next ? bus.br_target : pc_inc;
                if (taken_next && (taken_cnt_reg != '1)) begin
                    taken_cnt_reg <= taken_cnt_reg + CNT_W'(1);
                end
            end else if (bus.res_ready) begin
                res_valid_reg <= 1'b0;
            end
        end
    end

    assign bus.br_ready    = br_ready_int;
    assign bus.res_valid   = res_valid_reg;
    assign bus.res_taken   = res_taken_reg;
    assign bus.res_next_pc = res_next_pc_reg;
    assign nzp             = nzp_reg;
    assign taken_cnt       = taken_cnt_reg;

    // The condition code must always be exactly one of N, Z, P.
    nzp_onehot_a: assert property (@(posedge clk) disable iff (rst) $onehot(nzp_reg));

endmodule

// File: tb/tb_lc4_nzp_branch_unit.sv
// Directed-vector bench for lc4_nzp_branch_unit; expectations are hand-computed
// and adapt to LC4_NZP_BYPASS_EN where the two builds differ.
module tb_lc4_nzp_branch_unit;
    import lc4_pkg::*;

    logic        clk;
    logic        rst;
    logic        wb_valid;
    logic        wb_nzp_we;
    logic [15:0] wb_value;
    nzp_t        nzp;
    logic [15:0] taken_cnt;

    int tests_run = 0;
    int fail_cnt  = 0;
    int exp_cnt   = 0;

    lc4_nzp_branch_unit_if #(.PC_W(16)) bif ();

    lc4_nzp_branch_unit #(.PC_W(16), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .wb_valid  (wb_valid),
        .wb_nzp_we (wb_nzp_we),
        .wb_value  (wb_value),
        .bus       (bif),
        .nzp       (nzp),
        .taken_cnt (taken_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_write(input logic [15:0] v);
        wb_valid  = 1'b1;
        wb_nzp_we = 1'b1;
        wb_value  = v;
        tick();
        wb_valid  = 1'b0;
        wb_nzp_we = 1'b0;
        $display("[TB] wb value=0x%04h -> nzp=%b", v, nzp);
    endtask

    task automatic branch(input logic [2:0] mask, input logic [15:0] pc, input logic [15:0] tgt);
        bif.br_valid  = 1'b1;
        bif.br_mask   = mask;
        bif.br_pc     = pc;
        bif.br_target = tgt;
        tick();
        bif.br_valid  = 1'b0;
        $display("[TB] br mask=%b pc=0x%04h tgt=0x%04h -> taken=%0d next=0x%04h cnt=%0d",
                 mask, pc, tgt, bif.res_taken, bif.res_next_pc, taken_cnt);
    endtask

    task automatic check_res(input string tag, input logic exp_taken, input logic [15:0] exp_next);
        check({tag, ".valid"}, 32'(bif.res_valid), 32'd1);
        check({tag, ".taken"}, 32'(bif.res_taken), 32'(exp_taken));
        check({tag, ".next"},  32'(bif.res_next_pc), 32'(exp_next));
        check({tag, ".cnt"},   32'(taken_cnt), 32'(exp_cnt));
    endtask

    initial begin
        logic [15:0] wvals [3];
        logic        byp_taken;
        wvals[0] = CMP_LT;
        wvals[1] = CMP_EQ;
        wvals[2] = CMP_GT;

        rst = 1'b1; wb_valid = 1'b0; wb_nzp_we = 1'b0; wb_value = '0;
        bif.br_valid = 1'b0; bif.br_mask = '0; bif.br_pc = '0; bif.br_target = '0;
        bif.res_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;

        check("rst.nzp",   32'(nzp), 32'h2);
        check("rst.valid", 32'(bif.res_valid), 32'h0);
        check("rst.taken", 32'(bif.res_taken), 32'h0);
        check("rst.next",  32'(bif.res_next_pc), 32'h0);
        check("rst.cnt",   32'(taken_cnt), 32'h0);
        check("rst.ready", 32'(bif.br_ready), 32'h1);

        // NZP decode of the three compare results
        wb_write(16'hFFFF); check("nzp.lt", 32'(nzp), 32'h4);
        wb_write(16'h0000); check("nzp.eq", 32'(nzp), 32'h2);
        wb_write(16'h0001); check("nzp.gt", 32'(nzp), 32'h1);

        // Write enable without valid, and valid without enable, both hold
        wb_valid = 1'b0; wb_nzp_we = 1'b1; wb_value = 16'h8000; tick();
        check("nzp.hold_nv", 32'(nzp), 32'h1);
        wb_valid = 1'b1; wb_nzp_we = 1'b0; wb_value = 16'h0000; tick();
        check("nzp.hold_nwe", 32'(nzp), 32'h1);
        wb_valid = 1'b0; wb_nzp_we = 1'b0;
        wb_write(16'h8000); check("nzp.neg_big", 32'(nzp), 32'h4);
        wb_write(16'h7FFF); check("nzp.pos_big", 32'(nzp), 32'h1);

        // Basic resolution with nzp=001
        branch(3'b001, 16'h0010, 16'h0020); exp_cnt = 1;
        check_res("br.p_taken", 1'b1, 16'h0020);
        branch(3'b110, 16'h0010, 16'h0020);
        check_res("br.nz_not", 1'b0, 16'h0011);

        // NOP mask never taken (with PC wrap), all-ones mask always taken
        for (int i = 0; i < 3; i++) begin
            wb_write(wvals[i]);
            branch(3'b000, 16'hFFFF, 16'h1234);
            check_res($sformatf("br.nop%0d", i), 1'b0, 16'h0000);
            branch(3'b111, 16'hFFFF, 16'h1234); exp_cnt++;
            check_res($sformatf("br.all%0d", i), 1'b1, 16'h1234);
        end

        // Backpressure: result A held while consumer stalls for 3 cycles (nzp=001)
        branch(3'b001, 16'h0100, 16'h0200); exp_cnt++;
        check_res("stall.a", 1'b1, 16'h0200);
        bif.res_ready = 1'b0;
        bif.br_valid = 1'b1; bif.br_mask = 3'b100; bif.br_pc = 16'h0300; bif.br_target = 16'h0400;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("stall.ready%0d", i), 32'(bif.br_ready), 32'h0);
            tick();
            check_res($sformatf("stall.hold%0d", i), 1'b1, 16'h0200);
        end
        bif.res_ready = 1'b1;
        #1;
        check("stall.release", 32'(bif.br_ready), 32'h1);
        tick();
        check_res("b2b.b", 1'b0, 16'h0301);
        bif.br_mask = 3'b011; bif.br_pc = 16'h0500; bif.br_target = 16'h0600;
        tick(); exp_cnt++;
        check_res("b2b.c", 1'b1, 16'h0600);
        bif.br_mask = 3'b010; bif.br_pc = 16'h0700; bif.br_target = 16'h0800;
        tick();
        check_res("b2b.d", 1'b0, 16'h0701);
        bif.br_valid = 1'b0;
        tick();
        check("b2b.drain", 32'(bif.res_valid), 32'h0);

        // Compare and dependent branch in the same cycle, old nzp=010
        wb_write(CMP_EQ);
`ifdef LC4_NZP_BYPASS_EN
        byp_taken = 1'b1;
`else
        byp_taken = 1'b0;
`endif
        wb_valid = 1'b1; wb_nzp_we = 1'b1; wb_value = CMP_LT;
        branch(3'b100, 16'h0800, 16'h0900);
        wb_valid = 1'b0; wb_nzp_we = 1'b0;
        if (byp_taken) exp_cnt++;
        check_res("same.br", byp_taken, byp_taken ? 16'h0900 : 16'h0801);
        check("same.nzp", 32'(nzp), 32'h4);

        // Reset arriving while a result is pending, alongside a write and a branch
        branch(3'b111, 16'h0A00, 16'h0B00); exp_cnt++;
        check_res("mid.pre", 1'b1, 16'h0B00);
        rst = 1'b1;
        bif.res_ready = 1'b0;
        wb_valid = 1'b1; wb_nzp_we = 1'b1; wb_value = CMP_GT;
        bif.br_valid = 1'b1; bif.br_mask = 3'b111;
        tick();
        rst = 1'b0; wb_valid = 1'b0; wb_nzp_we = 1'b0; bif.br_valid = 1'b0;
        bif.res_ready = 1'b1;
        $display("[TB] mid-stream reset -> nzp=%b valid=%0d cnt=%0d", nzp, bif.res_valid, taken_cnt);
        check("mid.nzp",   32'(nzp), 32'h2);
        check("mid.valid", 32'(bif.res_valid), 32'h0);
        check("mid.taken", 32'(bif.res_taken), 32'h0);
        check("mid.next",  32'(bif.res_next_pc), 32'h0);
        check("mid.cnt",   32'(taken_cnt), 32'h0);

        exp_cnt = 1;
        branch(3'b010, 16'h0C00, 16'h0D00);
        check_res("post.z", 1'b1, 16'h0D00);

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
        $finish;
    end

endmodule

// File: doc/lc4_nzp_branch_unit.md
Name: lc4_nzp_branch_unit

Overview:
Consumer end of the LC4 compare path. Takes 16-bit results from CMP/CMPU/CMPI/CMPUI and from other NZP-setting instructions, and reduces each to an N/Z/P condition code. Holds that code in the architectural NZP register and resolves BR[nzp] branches against it. Emits registered redirect results through a one-entry valid/ready output buffer toward the fetch stage.

Parameters:
- PC_W, 16, width of PC and branch target fields.
- CNT_W, 16, width of the saturating taken-branch counter.

Ports:
- clk  in  1  system clock, all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- wb_valid  in  1  writeback slot holds a retiring instruction.
- wb_nzp_we  in  1  that instruction sets NZP; ignored unless wb_valid.
- wb_value  in  16  result word; compare results arrive as 0xFFFF, 0x0000 or 0x0001.
- br_valid  in  1  branch request present.
- br_ready  out  1  unit accepts a branch this cycle.
- br_mask  in  3  insn[11:9] n,z,p mask.
- br_pc  in  PC_W  PC of the branch.
- br_target  in  PC_W  precomputed PC+1+IMM9.
- res_valid  out  1  result buffer holds a resolved branch.
- res_ready  in  1  consumer takes the result.
- res_taken  out  1  branch taken.
- res_next_pc  out  PC_W  br_target if taken, else br_pc+1 (mod 2^PC_W).
- nzp  out  3  architectural NZP register {N,Z,P}.
- taken_cnt  out  CNT_W  count of taken branches.

Behaviour:
- Reset: nzp=3'b010, res_valid=0, res_taken=0, res_next_pc=0, taken_cnt=0. Reset overrides all same-cycle events; an in-flight result is dropped.
- NZP decode, signed: N=wb_value[15]; Z=(wb_value==0); P=otherwise. Exactly one bit is set.
- NZP write: when wb_valid&&wb_nzp_we, nzp takes the decode at the next edge. Otherwise nzp holds.
- Handshake: br_ready = !res_valid || res_ready. A branch is accepted when br_valid&&br_ready.
- Resolution uses the registered nzp; see Optional Feature for the bypass case.
- taken = |(br_mask & nzp_used).
  - br_mask=000 is never taken (NOP).
  - br_mask=111 is always taken.
- Latency: acceptance in cycle t; res_* valid from cycle t+1.
- Output buffer:
  - Holds its contents stable while res_valid && !res_ready.
  - Clears when res_ready and no new accept.
  - On simultaneous drain and accept, reloads in the same cycle with no bubble; the full rate is one branch per cycle.
- PC+1 wraps: br_pc=0xFFFF gives a not-taken res_next_pc of 0x0000.
- taken_cnt increments on each accepted taken branch and saturates at all-ones.
- A wb write and a branch accept in the same cycle: the branch sees the old nzp (bypass off); nzp updates at the edge regardless.

Optional Feature:
- Macro LC4_NZP_BYPASS_EN.
- Defined: when wb_valid&&wb_nzp_we in the accept cycle, nzp_used is the decode of wb_value, giving CMP-then-BR with no bubble.
- Undefined: nzp_used is always the registered nzp, and the pipeline must insert a bubble between a compare and a dependent branch.
- The nzp output port is the registered value in both builds.

Decomposition:
- Shared package lc4_pkg:
  - NZP_N/NZP_Z/NZP_P bit indices.
  - NZP_RESET=3'b010.
  - nzp_t 3-bit typedef.
  - CMP_GT=16'h0001, CMP_EQ=16'h0000, CMP_LT=16'hFFFF.
- One sub-module, lc4_nzp_decode: combinational 16-bit to 3-bit NZP decode. It is instantiated twice, for the register write and for the bypass.

Test Plan:
- Reset, then assert rst mid-stream while res_valid=1 -> next cycle nzp=010, res_valid=0, taken_cnt=0.
- wb_value=0xFFFF, then 0x0000, then 0x0001, each with wb_nzp_we=1 -> nzp=100, then 010, then 001.
- nzp=001; branch br_mask=001, br_pc=0x0010, br_target=0x0020 -> res_taken=1, res_next_pc=0x0020; then br_mask=110 -> taken=0, res_next_pc=0x0011.
- br_mask=000 with each nzp value -> never taken; br_pc=0xFFFF not taken -> res_next_pc=0x0000.
- Hold res_ready=0 for 3 cycles with br_valid=1 -> br_ready=0, res_* stable, no counter change; release -> one branch per cycle, back-to-back.
- CMP result 0xFFFF and branch br_mask=100 in the same cycle, old nzp=010 -> taken=1 with LC4_NZP_BYPASS_EN, taken=0 without it.
